// File: rtl/rs_alu_if.sv
// Dispatch / CDB / issue bundle between the front end, the ALU reservation station and the ALU.
interface rs_alu_if #(
    parameter int TAG_W = 5
) ();
    logic             rdy;
    logic             clr;
    logic             disp_vld;
    logic [3:0]       disp_opcode;
    logic [3:0]       disp_optype;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic             disp_qj_vld;
    logic             disp_qk_vld;
    logic [TAG_W-1:0] disp_qj;
    logic [TAG_W-1:0] disp_qk;
    logic [31:0]      disp_imm;
    logic [31:0]      disp_pc;
    logic [TAG_W-1:0] disp_rd;
    logic             full;
    logic             cdb0_vld;
    logic             cdb1_vld;
    logic [TAG_W-1:0] cdb0_tag;
    logic [TAG_W-1:0] cdb1_tag;
    logic [31:0]      cdb0_val;
    logic [31:0]      cdb1_val;
    logic             run_flg;
    logic [TAG_W-1:0] rd_fr;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [3:0]       opcode;
    logic [3:0]       optype;

    modport master (
        output rdy, clr, disp_vld, disp_opcode, disp_optype, disp_vj, disp_vk,
               disp_qj_vld, disp_qk_vld, disp_qj, disp_qk, disp_imm, disp_pc, disp_rd,
               cdb0_vld, cdb1_vld, cdb0_tag, cdb1_tag, cdb0_val, cdb1_val,
        input  full, run_flg, rd_fr, vj, vk, imm, pc, opcode, optype
    );

    modport slave (
        input  rdy, clr, disp_vld, disp_opcode, disp_optype, disp_vj, disp_vk,
               disp_qj_vld, disp_qk_vld, disp_qj, disp_qk, disp_imm, disp_pc, disp_rd,
               cdb0_vld, cdb1_vld, cdb0_tag, cdb1_tag, cdb0_val, cdb1_val,
        output full, run_flg, rd_fr, vj, vk, imm, pc, opcode, optype
    );
endinterface

// File: rtl/rs_alu.sv
// Integer ALU reservation station: captures operands from two CDB ports, issues one ready op per cycle.
// Define RS_AGE_ISSUE_EN for oldest-first issue; default is lowest-index-first.
module rs_alu #(
    parameter int RS_SZ = 16,
    parameter int TAG_W = 5
) (
    input  logic    clk,
    input  logic    rst_n,
    rs_alu_if.slave bus
);
    localparam int IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;

    logic [RS_SZ-1:0] r_busy, r_qj_vld, r_qk_vld;
    logic [3:0]       r_opcode [RS_SZ];
    logic [3:0]       r_optype [RS_SZ];
    logic [31:0]      r_vj     [RS_SZ];
    logic [31:0]      r_vk     [RS_SZ];
    logic [31:0]      r_imm    [RS_SZ];
    logic [31:0]      r_pc     [RS_SZ];
    logic [TAG_W-1:0] r_qj     [RS_SZ];
    logic [TAG_W-1:0] r_qk     [RS_SZ];
    logic [TAG_W-1:0] r_rd     [RS_SZ];

    logic             r_run_p1;
    logic [TAG_W-1:0] r_rd_p1;
    logic [31:0]      r_vj_p1, r_vk_p1, r_imm_p1, r_pc_p1;
    logic [3:0]       r_opcode_p1, r_optype_p1;

    logic [RS_SZ-1:0] w_ready, w_mj0, w_mj1, w_mk0, w_mk1;
    logic [IDX_W-1:0] w_free_idx, w_sel;
    logic             w_full, w_issue;
    logic             w_bj0, w_bj1, w_bk0, w_bk1, w_dqj_pend, w_dqk_pend;
    logic [31:0]      w_dvj, w_dvk;

`ifdef RS_AGE_ISSUE_EN
    localparam int AGE_W = IDX_W + 1;
    logic [AGE_W-1:0] r_age [RS_SZ];
    logic [AGE_W-1:0] w_best_age, w_cnt;
`endif

    always_comb begin
        w_full     = &r_busy;
        w_free_idx = '0;
        w_sel      = '0;
        w_issue    = 1'b0;
`ifdef RS_AGE_ISSUE_EN
        w_best_age = '1;
        w_cnt      = '0;
`endif
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_SZ; i++) begin
            w_ready[i] = r_busy[i] & ~r_qj_vld[i] & ~r_qk_vld[i];
            w_mj0[i]   = bus.cdb0_vld && (bus.cdb0_tag == r_qj[i]);
            w_mj1[i]   = bus.cdb1_vld && (bus.cdb1_tag == r_qj[i]);
            w_mk0[i]   = bus.cdb0_vld && (bus.cdb0_tag == r_qk[i]);
            w_mk1[i]   = bus.cdb1_vld && (bus.cdb1_tag == r_qk[i]);
`ifdef RS_AGE_ISSUE_EN
            w_cnt = w_cnt + AGE_W'(r_busy[i]);
            // strict compare keeps the lowest index among equal ages
            if (w_ready[i] && (!w_issue || (r_age[i] < w_best_age))) begin
                w_issue    = 1'b1;
                w_sel      = IDX_W'(i);
                w_best_age = r_age[i];
            end
`else
            if (w_ready[i] && !w_issue) begin
                w_issue = 1'b1;
                w_sel   = IDX_W'(i);
            end
`endif
        end
    end

    // Same-cycle CDB bypass into the entry being dispatched; port 0 wins on a tag collision.
    always_comb begin
        w_bj0      = bus.cdb0_vld && (bus.cdb0_tag == bus.disp_qj);
        w_bj1      = bus.cdb1_vld && (bus.cdb1_tag == bus.disp_qj);
        w_bk0      = bus.cdb0_vld && (bus.cdb0_tag == bus.disp_qk);
        w_bk1      = bus.cdb1_vld && (bus.cdb1_tag == bus.disp_qk);
        w_dqj_pend = bus.disp_qj_vld && !(w_bj0 || w_bj1);
        w_dqk_pend = bus.disp_qk_vld && !(w_bk0 || w_bk1);
        w_dvj      = bus.disp_vj;
        w_dvk      = bus.disp_vk;
        if (bus.disp_qj_vld && w_bj0)      w_dvj = bus.cdb0_val;
        else if (bus.disp_qj_vld && w_bj1) w_dvj = bus.cdb1_val;
        if (bus.disp_qk_vld && w_bk0)      w_dvk = bus.cdb0_val;
        else if (bus.disp_qk_vld && w_bk1) w_dvk = bus.cdb1_val;
    end

    // Control state and issue register stage (_p1)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_qj_vld    <= '0;
            r_qk_vld    <= '0;
            r_run_p1    <= 1'b0;
            r_rd_p1     <= '0;
            r_vj_p1     <= '0;
            r_vk_p1     <= '0;
            r_imm_p1    <= '0;
            r_pc_p1     <= '0;
            r_opcode_p1 <= '0;
            r_optype_p1 <= '0;
        end else if (bus.rdy) begin
            if (bus.clr) begin
                r_busy   <= '0;
                r_run_p1 <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SZ; i++) begin
                    if (r_busy[i] && (w_mj0[i] || w_mj1[i])) r_qj_vld[i] <= 1'b0;
                    if (r_busy[i] && (w_mk0[i] || w_mk1[i])) r_qk_vld[i] <= 1'b0;
`ifdef RS_AGE_ISSUE_EN
                    if (w_issue && r_busy[i] && (r_age[i] > r_age[w_sel]))
                        r_age[i] <= r_age[i] - 1'b1;
`endif
                end
                r_run_p1 <= w_issue;
                if (w_issue) begin
                    r_busy[w_sel] <= 1'b0;
                    r_rd_p1       <= r_rd[w_sel];
                    r_vj_p1       <= r_vj[w_sel];
                    r_vk_p1       <= r_vk[w_sel];
                    r_imm_p1      <= r_imm[w_sel];
                    r_pc_p1       <= r_pc[w_sel];
                    r_opcode_p1   <= r_opcode[w_sel];
                    r_optype_p1   <= r_optype[w_sel];
                end
                if (bus.disp_vld && !w_full) begin
                    r_busy[w_free_idx]   <= 1'b1;
                    r_qj_vld[w_free_idx] <= w_dqj_pend;
                    r_qk_vld[w_free_idx] <= w_dqk_pend;
`ifdef RS_AGE_ISSUE_EN
                    r_age[w_free_idx] <= w_issue ? (w_cnt - 1'b1) : w_cnt;
`endif
                end
            end
        end
    end

    // Entry payload: no reset, only written while operating
    always_ff @(posedge clk) begin
        if (rst_n && bus.rdy && !bus.clr) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (r_busy[i] && r_qj_vld[i]) begin
                    if (w_mj0[i])      r_vj[i] <= bus.cdb0_val;
                    else if (w_mj1[i]) r_vj[i] <= bus.cdb1_val;
                end
                if (r_busy[i] && r_qk_vld[i]) begin
                    if (w_mk0[i])      r_vk[i] <= bus.cdb0_val;
                    else if (w_mk1[i]) r_vk[i] <= bus.cdb1_val;
                end
            end
            if (bus.disp_vld && !w_full) begin
                r_opcode[w_free_idx] <= bus.disp_opcode;
                r_optype[w_free_idx] <= bus.disp_optype;
                r_vj[w_free_idx]     <= w_dvj;
                r_vk[w_free_idx]     <= w_dvk;
                r_qj[w_free_idx]     <= bus.disp_qj;
                r_qk[w_free_idx]     <= bus.disp_qk;
                r_imm[w_free_idx]    <= bus.disp_imm;
                r_pc[w_free_idx]     <= bus.disp_pc;
                r_rd[w_free_idx]     <= bus.disp_rd;
            end
        end
    end

    assign bus.full    = w_full;
    assign bus.run_flg = r_run_p1;
    assign bus.rd_fr   = r_rd_p1;
    assign bus.vj      = r_vj_p1;
    assign bus.vk      = r_vk_p1;
    assign bus.imm     = r_imm_p1;
    assign bus.pc      = r_pc_p1;
    assign bus.opcode  = r_opcode_p1;
    assign bus.optype  = r_optype_p1;
endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_rs_alu;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy_q = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  op, ty;
    } exp_t;
    exp_t q[$];

    rs_alu_if #(.TAG_W(5)) bus ();
    rs_alu #(.RS_SZ(16), .TAG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) rdy_q <= bus.rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_vld = 1'b0;
        bus.cdb0_vld = 1'b0;
        bus.cdb1_vld = 1'b0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [3:0] op, input logic [3:0] ty);
        exp_t e;
        e.rd = rd; e.vj = vj; e.vk = vk; e.imm = imm; e.pc = pc; e.op = op; e.ty = ty;
        q.push_back(e);
    endtask

    task automatic disp(input logic [3:0] op, input logic [3:0] ty,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic qjv, input logic [4:0] qj,
                        input logic qkv, input logic [4:0] qk,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        bus.disp_vld    = 1'b1;
        bus.disp_opcode = op;
        bus.disp_optype = ty;
        bus.disp_vj     = vj;
        bus.disp_vk     = vk;
        bus.disp_qj_vld = qjv;
        bus.disp_qj     = qj;
        bus.disp_qk_vld = qkv;
        bus.disp_qk     = qk;
        bus.disp_imm    = imm;
        bus.disp_pc     = pc;
        bus.disp_rd     = rd;
    endtask

    task automatic cdb(input int port, input logic [4:0] tag, input logic [31:0] val);
        if (port == 0) begin
            bus.cdb0_vld = 1'b1; bus.cdb0_tag = tag; bus.cdb0_val = val;
        end else begin
            bus.cdb1_vld = 1'b1; bus.cdb1_tag = tag; bus.cdb1_val = val;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rdy_q && bus.run_flg) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL iss_unexpected rd_fr actual=%0d expected=no_issue", bus.rd_fr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("iss_rd", 32'(bus.rd_fr), 32'(e.rd));
                chk("iss_vj", bus.vj, e.vj);
                chk("iss_vk", bus.vk, e.vk);
                chk("iss_imm", bus.imm, e.imm);
                chk("iss_pc", bus.pc, e.pc);
                chk("iss_opcode", 32'(bus.opcode), 32'(e.op));
                chk("iss_optype", 32'(bus.optype), 32'(e.ty));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.rdy = 1'b1;
        bus.clr = 1'b0;
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        bus.cdb0_tag = '0; bus.cdb0_val = '0;
        bus.cdb1_tag = '0; bus.cdb1_val = '0;
        repeat (3) tick();
        chk("rst_run", 32'(bus.run_flg), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_vj", bus.vj, 0);
        chk("rst_rd_fr", 32'(bus.rd_fr), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        rst_n = 1'b1;

        // ready ADD issues one edge after dispatch
        push(3, 5, 7, 0, 32'h100, 1, 0);
        disp(1, 0, 5, 7, 0, 0, 0, 0, 0, 32'h100, 3);
        tick(); idle();
        chk("t1_lat0", 32'(bus.run_flg), 0);
        tick(); chk("t1_run", 32'(bus.run_flg), 1);
        tick(); chk("t1_done", 32'(bus.run_flg), 0);

        // ADDI waiting on tag 4, woken by cdb1
        push(5, 32'h10, 32'h22, 32'h33, 32'h104, 2, 1);
        disp(2, 1, 32'hdead, 32'h22, 1, 4, 0, 0, 32'h33, 32'h104, 5);
        tick(); idle();
        repeat (3) begin tick(); chk("t2_wait", 32'(bus.run_flg), 0); end
        cdb(1, 4, 32'h10);
        tick(); idle();
        chk("t2_cap", 32'(bus.run_flg), 0);
        tick(); chk("t2_run", 32'(bus.run_flg), 1);
        tick(); chk("t2_done", 32'(bus.run_flg), 0);

        // dispatch bypass from cdb0 on qk
        push(6, 1, 32'habcd, 0, 32'h108, 3, 0);
        disp(3, 0, 1, 32'hdead, 0, 0, 1, 6, 0, 32'h108, 6);
        cdb(0, 6, 32'habcd);
        tick(); idle();
        chk("t3_lat0", 32'(bus.run_flg), 0);
        tick(); chk("t3_run", 32'(bus.run_flg), 1);
        tick(); chk("t3_done", 32'(bus.run_flg), 0);

        // fill all 16 entries pending on tag 9
        for (int i = 0; i < 16; i++) begin
            push(5'(i), 32'h99, 32'h100 + i, 32'(i), 32'h2000 + 4 * i, 4'(i), 2);
            disp(4'(i), 2, 0, 32'h100 + i, 1, 9, 0, 0, 32'(i), 32'h2000 + 4 * i, 5'(i));
            tick();
        end
        idle();
        chk("t4_full", 32'(bus.full), 1);
        chk("t4_idle", 32'(bus.run_flg), 0);
        disp(15, 2, 0, 0, 0, 0, 0, 0, 0, 0, 31);
        tick(); idle();
        chk("t4_drop_full", 32'(bus.full), 1);
        cdb(0, 9, 32'h99);
        tick(); idle();
        chk("t4_cap_full", 32'(bus.full), 1);
        chk("t4_cap_run", 32'(bus.run_flg), 0);
        disp(14, 2, 0, 0, 0, 0, 0, 0, 0, 0, 30);
        tick(); idle();
        chk("t4_first", 32'(bus.run_flg), 1);
        chk("t4_slot_not_reused", 32'(bus.full), 0);
        repeat (15) begin tick(); chk("t4_stream", 32'(bus.run_flg), 1); end
        tick();
        chk("t4_end_run", 32'(bus.run_flg), 0);
        chk("t4_end_full", 32'(bus.full), 0);

        // flush with 8 busy and a same-cycle dispatch
        for (int i = 0; i < 8; i++) begin
            disp(7, 0, 0, 0, 1, 10, 0, 0, 0, 0, 5'(20 + i));
            tick();
        end
        idle();
        chk("t5_pre_full", 32'(bus.full), 0);
        disp(8, 0, 32'h55, 32'h66, 0, 0, 0, 0, 0, 0, 25);
        bus.clr = 1'b1;
        tick(); bus.clr = 1'b0; idle();
        chk("t5_run", 32'(bus.run_flg), 0);
        chk("t5_full", 32'(bus.full), 0);
        cdb(0, 10, 32'h1);
        tick(); idle();
        repeat (3) begin tick(); chk("t5_quiet", 32'(bus.run_flg), 0); end

        // stall with a ready entry and a CDB broadcast
        disp(9, 0, 0, 32'ha, 1, 12, 0, 0, 1, 32'h300, 8);
        tick();
        push(7, 32'h77, 32'h88, 2, 32'h304, 5, 1);
        disp(5, 1, 32'h77, 32'h88, 0, 0, 0, 0, 2, 32'h304, 7);
        tick(); idle();
        push(8, 32'h1212, 32'ha, 1, 32'h300, 9, 0);
        bus.rdy = 1'b0;
        cdb(0, 12, 32'h5555);
        repeat (4) begin
            tick();
            chk("t6_stall_run", 32'(bus.run_flg), 0);
            chk("t6_stall_rd", 32'(bus.rd_fr), 15);
            chk("t6_stall_vj", bus.vj, 32'h99);
        end
        bus.rdy = 1'b1;
        idle();
        tick(); chk("t6_resume", 32'(bus.run_flg), 1);
        tick(); chk("t6_cdb_lost", 32'(bus.run_flg), 0);
        cdb(0, 12, 32'h1212);
        tick(); idle();
        chk("t6_cap", 32'(bus.run_flg), 0);
        tick(); chk("t6_run", 32'(bus.run_flg), 1);
        tick(); chk("t6_done", 32'(bus.run_flg), 0);

        tick();
        chk("sb_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
